// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types, constants and helpers for the iterative multiply/divide sequencer
package muldiv_pkg;

  localparam int   XLEN    = 32;
  localparam int   STEPS   = 32;
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  // Magnitude as unsigned; 0x80000000 maps onto itself.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - signed MULT (shift-add) / DIV (restoring), one bit per cycle
// Shares one 65-bit accumulator between both operations; sign fixup happens in FIX.
import muldiv_pkg::*;

module muldiv_sequencer (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy,
  output logic            done,
  output logic            write_hi,
  output logic            write_lo,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_t      state, next_state;
  logic        op_q, sign_a, sign_b, dz;
  logic [31:0] mag_a, mag_b;
  logic [4:0]  count;
  logic [64:0] acc;

  logic [32:0] mul_sum;
  logic [64:0] mul_next, div_shift, div_next;
  logic [33:0] div_trial;
  logic [63:0] prod;
  logic [31:0] quot, rem, fix_hi, fix_lo;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == DONE);
    write_hi   = (state == DONE) && !dz;
    write_lo   = (state == DONE) && !dz;
    div_zero   = (state == DONE) && dz;
    case (state)
      IDLE: if (start) next_state = (op == OP_DIV && b_in == 32'd0) ? DONE : RUN;
      RUN:  if (count == 5'(STEPS - 1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MULT: {carry, P_hi, P_lo}; DIV: {R[32:0], Q[31:0]}
  always_comb begin
    mul_sum   = {acc[64], acc[63:32]} + {1'b0, (acc[0] ? mag_a : 32'd0)};
    mul_next  = {1'b0, mul_sum, acc[31:1]};
    div_shift = {acc[63:0], 1'b0};
    div_trial = {1'b0, div_shift[64:32]} - {2'b00, mag_b};
    div_next  = div_trial[33] ? div_shift : {div_trial[32:0], div_shift[31:1], 1'b1};
    prod      = (sign_a ^ sign_b) ? neg64(acc[63:0]) : acc[63:0];
    quot      = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
    rem       = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];
    fix_hi    = (op_q == OP_DIV) ? rem  : prod[63:32];
    fix_lo    = (op_q == OP_DIV) ? quot : prod[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      dz     <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      count  <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op;
          sign_a <= a_in[31];
          sign_b <= b_in[31];
          mag_a  <= abs32(a_in);
          mag_b  <= abs32(b_in);
          count  <= '0;
          dz     <= (op == OP_DIV) && (b_in == 32'd0);
          acc    <= {33'd0, (op == OP_DIV) ? abs32(a_in) : abs32(b_in)};
        end
        RUN: begin
          acc   <= (op_q == OP_DIV) ? div_next : mul_next;
          count <= count + 5'd1;
        end
        FIX: begin
          hi <= fix_hi;
          lo <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;
  logic        busy, done, write_hi, write_lo, div_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] mh = '0, ml = '0;

  muldiv_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .write_hi(write_hi), .write_lo(write_lo),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        o;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] ph, input logic [31:0] pl,
                                output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    edz = 1'b0;
    if (!o) begin
      p = sa * sb;
      eh = p[63:32];
      el = p[31:0];
    end else if (b == 32'd0) begin
      edz = 1'b1;
      eh = ph;
      el = pl;
    end else begin
      q = sa / sb;
      r = sa % sb;
      eh = r[31:0];
      el = q[31:0];
    end
  endfunction

  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input bit inject);
    int busy_cnt, done_cnt, done_cyc, stray;
    logic got_wh, got_wl, got_dz;
    bit finished;
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; stray = 0; finished = 0;
    got_wh = 0; got_wl = 0; got_dz = 0;
    @(negedge clock);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; op = 1'($urandom); a_in = $urandom; b_in = $urandom;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++; done_cyc = c;
        got_wh = write_hi; got_wl = write_lo; got_dz = div_zero;
      end else if (write_hi | write_lo | div_zero) stray++;
      start = inject && (c == 4 || c == 19);
      if (!busy) begin finished = 1; break; end
    end
    start = 1'b0;
    chk({tag, " finished"}, 64'(finished), 64'd1);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_cycle"}, 64'(done_cyc), edz ? 64'd0 : 64'd33);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), edz ? 64'd1 : 64'd34);
    chk({tag, " div_zero"}, 64'(got_dz), 64'(edz));
    chk({tag, " write_hi"}, 64'(got_wh), 64'(!edz));
    chk({tag, " write_lo"}, 64'(got_wl), 64'(!edz));
    chk({tag, " stray_strobes"}, 64'(stray), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    if (!edz) begin mh = eh; ml = el; end
  endtask

  vec_t vecs[6];
  logic [31:0] corners[6];

  initial begin
    int dones;
    logic [31:0] eh, el, ra, rb;
    logic edz, ro;

    vecs[0] = '{1'b0, 32'd3,          32'd4,          32'd0,          32'd12,         1'b0};
    vecs[1] = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd12,         1'b1};
    vecs[2] = '{1'b0, 32'd7,          32'hFFFFFFFD,   32'hFFFFFFFF,   32'hFFFFFFEB,   1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0};
    vecs[4] = '{1'b0, 32'h80000000,   32'h80000000,   32'h40000000,   32'd0,          1'b0};
    vecs[5] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0};
    corners = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd1, 32'h7FFFFFFF, 32'hFFFFFFFE};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset strobes", 64'({write_hi, write_lo, div_zero}), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, vecs[i].edz, 1'b0);

    run_op("ignore_start", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);

    @(negedge clock);
    op = 1'b1; a_in = 32'd1000; b_in = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    mh = '0; ml = '0;
    @(negedge clock);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done) dones++;
    end
    chk("midreset no_done", 64'(dones), 64'd0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(20, 31);
      model(ro, ra, rb, mh, ml, eh, el, edz);
      run_op($sformatf("rand%0d_%s_%h_%h", i, ro ? "div" : "mul", ra, rb), ro, ra, rb, eh, el, edz, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
